// File: rtl/mult_div_seq_if.sv
// Issue/result bundle between the EX-stage pipeline and the mult/div sequencer.
// Handshake: an operation is accepted on a rising edge where start=1, flush=0
// and the sequencer is idle (busy=0); op/a/b are captured on that edge only.
// While busy=1 further start pulses are ignored. done is a one-cycle pulse that
// coincides with the new hi/lo/div_by_zero values; flush cancels silently.
interface mult_div_seq_if #(
    parameter int size = 31
);
    localparam int W = size + 1;

    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;
    logic [1:0]   state_dbg;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo, div_by_zero, state_dbg
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo, div_by_zero, state_dbg
    );
endinterface

// File: rtl/mult_div_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one bit per cycle through a single
// shared adder, sign fix-up in a final cycle, results held in HI/LO.
module mult_div_seq #(
    parameter int size = 31
) (
    input  logic           clk,
    input  logic           rst_n,
    mult_div_seq_if.slave  bus
);
    localparam int W  = size + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;      // product upper half / partial remainder
    logic [W-1:0]   mq_q, mq_d;        // multiplier / quotient shift register
    logic [W-1:0]   opnd_q, opnd_d;    // |multiplicand| or |divisor|
    logic [W-1:0]   a_raw_q, a_raw_d;  // dividend as issued, for the b==0 result
    logic           neg_res_q, neg_res_d;
    logic           neg_rem_q, neg_rem_d;
    logic           b_zero_q, b_zero_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [W-1:0]   lo_q, lo_d;
    logic           done_q, done_d;
    logic           dbz_q, dbz_d;

    // Shared adder: multiply adds the multiplicand, divide subtracts the
    // divisor as x + ~y + 1; the top bit is the carry (no-borrow for divide).
    logic [W:0]     add_x, add_y;
    logic           add_cin;
    logic [W+1:0]   add_sum;

    logic           is_div;
    logic           accept;
    logic           last_iter;
    logic [W:0]     rem_sh;
    logic           sgn_a, sgn_b;
    logic [W-1:0]   abs_a, abs_b;
    logic [2*W-1:0] prod_u, prod_f;

    assign is_div    = op_q[1];
    assign accept    = bus.start && !bus.flush;
    assign last_iter = (cnt_q == CW'(W - 1));
    assign rem_sh    = {acc_q, mq_q[W-1]};

    // Adder operand selection depends only on the latched operation.
    always_comb begin
        add_x   = {1'b0, acc_q};
        add_y   = {1'b0, opnd_q};
        add_cin = 1'b0;
        if (is_div) begin
            add_x   = rem_sh;
            add_y   = ~{1'b0, opnd_q};
            add_cin = 1'b1;
        end
        add_sum = {1'b0, add_x} + {1'b0, add_y} + {{(W + 1){1'b0}}, add_cin};
    end

    // State register plus all datapath/result flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            a_raw_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            a_raw_q   <= a_raw_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    // Next state: flush always wins, including over a start in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN: begin
                if (bus.flush)     state_d = S_IDLE;
                else if (last_iter) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and result updates for each state.
    always_comb begin
        op_d      = op_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        a_raw_d   = a_raw_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;

        sgn_a  = bus.op[0] & bus.a[W-1];
        sgn_b  = bus.op[0] & bus.b[W-1];
        abs_a  = sgn_a ? -bus.a : bus.a;
        abs_b  = sgn_b ? -bus.b : bus.b;
        prod_u = {acc_q, mq_q};
        prod_f = neg_res_q ? -prod_u : prod_u;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d      = bus.op;
                    cnt_d     = '0;
                    acc_d     = '0;
                    a_raw_d   = bus.a;
                    neg_res_d = sgn_a ^ sgn_b;
                    neg_rem_d = sgn_a;
                    b_zero_d  = (bus.b == '0);
                    dbz_d     = 1'b0;
                    if (bus.op[1]) begin
                        mq_d   = abs_a;
                        opnd_d = abs_b;
                    end else begin
                        mq_d   = abs_b;
                        opnd_d = abs_a;
                    end
                end
            end
            S_RUN: begin
                if (!bus.flush) begin
                    cnt_d = cnt_q + CW'(1);
                    if (is_div) begin
                        if (add_sum[W+1]) begin
                            acc_d = add_sum[W-1:0];
                            mq_d  = {mq_q[W-2:0], 1'b1};
                        end else begin
                            acc_d = rem_sh[W-1:0];
                            mq_d  = {mq_q[W-2:0], 1'b0};
                        end
                    end else begin
                        if (mq_q[0]) begin
                            acc_d = add_sum[W:1];
                            mq_d  = {add_sum[0], mq_q[W-1:1]};
                        end else begin
                            acc_d = {1'b0, acc_q[W-1:1]};
                            mq_d  = {acc_q[0], mq_q[W-1:1]};
                        end
                    end
                end
            end
            S_FIX: begin
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!is_div) begin
                        hi_d = prod_f[2*W-1:W];
                        lo_d = prod_f[W-1:0];
                    end else if (b_zero_q) begin
                        hi_d  = a_raw_q;
                        lo_d  = '1;
                        dbz_d = 1'b1;
                    end else begin
                        hi_d = neg_rem_q ? -acc_q : acc_q;
                        lo_d = neg_res_q ? -mq_q : mq_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // Status outputs straight from flops.
    always_comb begin
        bus.busy        = (state_q != S_IDLE);
        bus.done        = done_q;
        bus.hi          = hi_q;
        bus.lo          = lo_q;
        bus.div_by_zero = dbz_q;
        bus.state_dbg   = state_q;
    end
endmodule

// File: tb/tb_mult_div_seq.sv
// Bench for mult_div_seq: directed scenarios plus random operations checked
// against an arithmetic model of MULT/MULTU/DIV/DIVU.
module tb_mult_div_seq;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [W-1:0] exp_q[$];

    mult_div_seq_if #(.size(31)) bus ();

    mult_div_seq #(.size(31)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero
    // and the remainder follows the dividend's sign.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] hi,
                                  output logic [W-1:0] lo, output logic dbz);
        longint unsigned up;
        longint sp;
        longint q;
        longint r;
        dbz = 1'b0;
        hi  = '0;
        lo  = '0;
        case (op)
            2'b00: begin
                up = {32'b0, a} * {32'b0, b};
                hi = up[63:32];
                lo = up[31:0];
            end
            2'b01: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                hi = sp[63:32];
                lo = sp[31:0];
            end
            default: begin
                if (b == '0) begin
                    hi  = a;
                    lo  = '1;
                    dbz = 1'b1;
                end else if (op == 2'b10) begin
                    hi = a % b;
                    lo = a / b;
                end else begin
                    q  = longint'($signed(a)) / longint'($signed(b));
                    r  = longint'($signed(a)) % longint'($signed(b));
                    hi = r[31:0];
                    lo = q[31:0];
                end
            end
        endcase
    endfunction

    // Issue one operation, wait for done, compare everything; returns in the
    // done cycle so a following call issues back-to-back.
    task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i,
                          input logic [W-1:0] b_i, input string tag);
        logic [W-1:0] eh, el, qh, ql;
        logic ed;
        int   lat;
        bit   busy_ok;
        bit   got;
        model(op_i, a_i, b_i, eh, el, ed);
        exp_q.push_back(eh);
        exp_q.push_back(el);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        tick();
        bus.start = 1'b0;
        bus.op    = 2'($urandom_range(0, 3));
        bus.a     = $urandom();
        bus.b     = $urandom();
        lat = 0;
        busy_ok = 1'b1;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
            if (bus.done === 1'b1) got = 1'b1;
        end
        qh = exp_q.pop_front();
        ql = exp_q.pop_front();
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s done_timeout: no done within %0d cycles, want 33", tag, lat);
        end
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL %s latency: got %0d want 33", tag, lat);
        end
        total++;
        if (!busy_ok) begin
            bad++;
            $display("FAIL %s busy_during_run: busy dropped before done, want high", tag);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL %s busy_at_done: got %b want 0", tag, bus.busy);
        end
        total++;
        if (bus.hi !== qh) begin
            bad++;
            $display("FAIL %s hi: got %h want %h", tag, bus.hi, qh);
        end
        total++;
        if (bus.lo !== ql) begin
            bad++;
            $display("FAIL %s lo: got %h want %h", tag, bus.lo, ql);
        end
        total++;
        if (bus.div_by_zero !== ed) begin
            bad++;
            $display("FAIL %s div_by_zero: got %b want %b", tag, bus.div_by_zero, ed);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        rst_n     = 1'b0;
        repeat (3) tick();
        total++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags: busy/done/dbz got %b want 000",
                     {bus.busy, bus.done, bus.div_by_zero});
        end
        total++;
        if ({bus.hi, bus.lo} !== 64'h0) begin
            bad++;
            $display("FAIL reset_hilo: got %h_%h want 0_0", bus.hi, bus.lo);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_multu_max();
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        tick();
        total++;
        if (bus.done !== 1'b0) begin
            bad++;
            $display("FAIL done_one_cycle: got %b want 0", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, "div_b2b");
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, "div_pos_neg");
        tick();
    endtask

    task automatic test_div_by_zero();
        run_op(2'b10, 32'd100, 32'd0, "divu_zero");
        run_op(2'b10, 32'd100, 32'd7, "divu_after_zero");
        run_op(2'b11, 32'hFFFF_FF00, 32'd0, "div_zero_neg");
        tick();
    endtask

    task automatic test_div_overflow();
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        tick();
    endtask

    task automatic test_random();
        logic [1:0]   op_r;
        logic [W-1:0] a_r, b_r;
        for (int i = 0; i < 24; i++) begin
            op_r = 2'($urandom_range(0, 3));
            a_r  = $urandom();
            case ($urandom_range(0, 3))
                0:       b_r = '0;
                1:       b_r = W'($urandom_range(1, 15));
                2:       b_r = -W'($urandom_range(1, 15));
                default: b_r = $urandom();
            endcase
            run_op(op_r, a_r, b_r, "random");
            if ($urandom_range(0, 1) == 0) tick();
        end
        tick();
    endtask

    // Ignored start while busy, flush in RUN, flush+start in IDLE, flush in FIX.
    task automatic test_flush();
        bit saw_done;
        bit stayed_idle;
        run_op(2'b00, 32'd5, 32'd6, "multu_5x6");
        tick();
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd9;
        bus.b     = 32'd2;
        tick();
        bus.start = 1'b0;
        saw_done  = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 5) begin
                bus.start = 1'b1;
                bus.op    = 2'b00;
                bus.a     = 32'd1;
                bus.b     = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            if (c == 10) bus.flush = 1'b1;
            tick();
            if (bus.done === 1'b1) saw_done = 1'b1;
        end
        bus.flush = 1'b0;
        bus.start = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_run_busy: got %b want 0", bus.busy);
        end
        stayed_idle = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.done === 1'b1) saw_done = 1'b1;
            if (bus.busy !== 1'b0) stayed_idle = 1'b0;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL flush_run_done: got done pulse want none");
        end
        total++;
        if (!stayed_idle) begin
            bad++;
            $display("FAIL flush_run_idle: busy rose after flush, want idle");
        end
        total++;
        if (bus.lo !== 32'd30 || bus.hi !== 32'd0) begin
            bad++;
            $display("FAIL flush_run_hold: got %h_%h want 00000000_0000001e", bus.hi, bus.lo);
        end
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_start_idle: busy got %b want 0", bus.busy);
        end
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd11;
        bus.b     = 32'd13;
        tick();
        bus.start = 1'b0;
        repeat (32) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL flush_fix: done/busy got %b%b want 00", bus.done, bus.busy);
        end
        total++;
        if (bus.lo !== 32'd30) begin
            bad++;
            $display("FAIL flush_fix_hold: lo got %h want 0000001e", bus.lo);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'hFFFF_0001;
        bus.b     = 32'h0000_1234;
        tick();
        bus.start = 1'b0;
        repeat (20) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || {bus.hi, bus.lo} !== 64'h0) begin
            bad++;
            $display("FAIL reset_mid: busy/done/dbz %b%b%b hi %h lo %h want all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run_op(2'b00, 32'd2, 32'd3, "multu_after_reset");
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        test_reset();
        test_multu_max();
        test_back_to_back();
        test_div_by_zero();
        test_div_overflow();
        test_flush();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
